// File: rtl/int_issue_queue.sv
// Integer issue queue: holds renamed instructions until dispatch, tracks operand readiness via wakeup broadcasts.
// Latency: an accepted insert, wakeup, dispatch or flush becomes visible one clk edge later; ins_ready is combinational.
// Backpressure: ins_ready drops when all DEPTH entries are valid, during flush, and while rst_n is low.
// Optional feature macro: INT_QUEUE_WAKEUP_BYPASS_EN (same-cycle writeback tags also mark an inserting entry's sources ready).
module int_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 6,
    parameter int ID_W      = 5,
    parameter int PAYLOAD_W = 40,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,

    // insert port from rename
    input  logic                       ins_valid,
    output logic                       ins_ready,
    input  logic [TAG_W-1:0]           ins_src1,
    input  logic [TAG_W-1:0]           ins_src2,
    input  logic                       ins_src1_rdy,
    input  logic                       ins_src2_rdy,
    input  logic [ID_W-1:0]            ins_al_id,
    input  logic [PAYLOAD_W-1:0]       ins_payload,

    // dispatch grant from the scheduler
    input  logic                       disp_valid,
    input  logic [IDX_W-1:0]           disp_index,

    // wakeup broadcasts (ALU, load)
    input  logic                       wb0_valid,
    input  logic [TAG_W-1:0]           wb0_tag,
    input  logic                       wb1_valid,
    input  logic [TAG_W-1:0]           wb1_tag,

    input  logic                       flush,

    // per-entry state, entry i at bits [i*W +: W]
    output logic [DEPTH-1:0]           q_valid,
    output logic [DEPTH-1:0]           q_rdy1,
    output logic [DEPTH-1:0]           q_rdy2,
    output logic [DEPTH*TAG_W-1:0]     q_src1,
    output logic [DEPTH*TAG_W-1:0]     q_src2,
    output logic [DEPTH*ID_W-1:0]      q_al_id,
    output logic [DEPTH*PAYLOAD_W-1:0] q_payload,
    output logic [CNT_W-1:0]           count
);

    // Control state (reset) and data fields (never reset; qualified by valid_q only)
    logic [DEPTH-1:0]                  valid_q;
    logic [DEPTH-1:0]                  rdy1_q;
    logic [DEPTH-1:0]                  rdy2_q;
    logic [CNT_W-1:0]                  count_q;
    logic [DEPTH-1:0][TAG_W-1:0]       src1_q;
    logic [DEPTH-1:0][TAG_W-1:0]       src2_q;
    logic [DEPTH-1:0][ID_W-1:0]        al_id_q;
    logic [DEPTH-1:0][PAYLOAD_W-1:0]   payload_q;

    logic [IDX_W-1:0]                  free_idx;
    logic                              free_found;
    logic                              do_ins;
    logic                              do_disp;
    logic [DEPTH-1:0]                  wake1;
    logic [DEPTH-1:0]                  wake2;
    logic                              ins_rdy1;
    logic                              ins_rdy2;

    // Gating with rst_n keeps ins_ready low during reset independent of the count flops.
    assign ins_ready = rst_n && !flush && (count_q < CNT_W'(DEPTH));
    assign do_ins    = ins_valid && ins_ready && free_found;
    // Dispatch of an entry that is not valid is a no-op and must not touch count.
    assign do_disp   = disp_valid && valid_q[disp_index] && !flush;

    // Lowest-index free entry; a dispatching entry is still valid here, so it is never the target.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // Tag match of each resident source against either broadcast; a duplicate tag is just an OR.
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = (wb0_valid && (wb0_tag == src1_q[i])) ||
                       (wb1_valid && (wb1_tag == src1_q[i]));
            wake2[i] = (wb0_valid && (wb0_tag == src2_q[i])) ||
                       (wb1_valid && (wb1_tag == src2_q[i]));
        end
    end

`ifdef INT_QUEUE_WAKEUP_BYPASS_EN
    // Catch a writeback that races the insert so the operand is not left waiting forever.
    assign ins_rdy1 = ins_src1_rdy ||
                      (wb0_valid && (wb0_tag == ins_src1)) ||
                      (wb1_valid && (wb1_tag == ins_src1));
    assign ins_rdy2 = ins_src2_rdy ||
                      (wb0_valid && (wb0_tag == ins_src2)) ||
                      (wb1_valid && (wb1_tag == ins_src2));
`else
    // The busy table already folds in same-cycle writebacks upstream.
    assign ins_rdy1 = ins_src1_rdy;
    assign ins_rdy2 = ins_src2_rdy;
`endif

    // Entry valid/ready bits and occupancy: flush dominates, then wakeup, dispatch and insert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    if (wake1[i]) rdy1_q[i] <= 1'b1;
                    if (wake2[i]) rdy2_q[i] <= 1'b1;
                end
                if (do_disp && (disp_index == IDX_W'(i))) begin
                    valid_q[i] <= 1'b0;
                end
                if (do_ins && (free_idx == IDX_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    rdy1_q[i]  <= ins_rdy1;
                    rdy2_q[i]  <= ins_rdy2;
                end
            end
            case ({do_ins, do_disp})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload capture into the insert target; freed entries simply keep stale contents.
    always_ff @(posedge clk) begin
        if (do_ins) begin
            src1_q[free_idx]    <= ins_src1;
            src2_q[free_idx]    <= ins_src2;
            al_id_q[free_idx]   <= ins_al_id;
            payload_q[free_idx] <= ins_payload;
        end
    end

    assign q_valid   = valid_q;
    assign q_rdy1    = rdy1_q;
    assign q_rdy2    = rdy2_q;
    assign q_src1    = src1_q;
    assign q_src2    = src2_q;
    assign q_al_id   = al_id_q;
    assign q_payload = payload_q;
    assign count     = count_q;

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed scenarios followed by random traffic against a reference model.
// Latency: checks land #1 after each rising edge; ins_ready is sampled before the edge.
// Backpressure: the model decides acceptance from its own occupancy and flush.
module tb_int_issue_queue;
    localparam int DEPTH     = 8;
    localparam int TAG_W     = 6;
    localparam int ID_W      = 5;
    localparam int PAYLOAD_W = 40;
    localparam int IDX_W     = 3;
    localparam int CNT_W     = 4;
`ifdef INT_QUEUE_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       ins_valid, ins_ready;
    logic [TAG_W-1:0]           ins_src1, ins_src2;
    logic                       ins_src1_rdy, ins_src2_rdy;
    logic [ID_W-1:0]            ins_al_id;
    logic [PAYLOAD_W-1:0]       ins_payload;
    logic                       disp_valid;
    logic [IDX_W-1:0]           disp_index;
    logic                       wb0_valid, wb1_valid;
    logic [TAG_W-1:0]           wb0_tag, wb1_tag;
    logic                       flush;
    logic [DEPTH-1:0]           q_valid, q_rdy1, q_rdy2;
    logic [DEPTH*TAG_W-1:0]     q_src1, q_src2;
    logic [DEPTH*ID_W-1:0]      q_al_id;
    logic [DEPTH*PAYLOAD_W-1:0] q_payload;
    logic [CNT_W-1:0]           count;

    int tests = 0;
    int fails = 0;

    // Reference model: one record per slot
    bit                   mvalid [DEPTH];
    bit                   mr1    [DEPTH];
    bit                   mr2    [DEPTH];
    logic [TAG_W-1:0]     ms1    [DEPTH];
    logic [TAG_W-1:0]     ms2    [DEPTH];
    logic [ID_W-1:0]      mid    [DEPTH];
    logic [PAYLOAD_W-1:0] mpay   [DEPTH];

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ID_W(ID_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_src1(ins_src1), .ins_src2(ins_src2),
        .ins_src1_rdy(ins_src1_rdy), .ins_src2_rdy(ins_src2_rdy),
        .ins_al_id(ins_al_id), .ins_payload(ins_payload),
        .disp_valid(disp_valid), .disp_index(disp_index),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag),
        .flush(flush),
        .q_valid(q_valid), .q_rdy1(q_rdy1), .q_rdy2(q_rdy2),
        .q_src1(q_src1), .q_src2(q_src2), .q_al_id(q_al_id), .q_payload(q_payload),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += mvalid[i];
        return n;
    endfunction

    function automatic bit wb_hit(input logic [TAG_W-1:0] t);
        return (wb0_valid && wb0_tag == t) || (wb1_valid && wb1_tag == t);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mvalid[i] = 0; mr1[i] = 0; mr2[i] = 0;
        end
    endtask

    // Apply one edge's worth of the behavioural rules to the model, using the inputs now driven.
    task automatic model_edge();
        int  free;
        bit  take;
        if (flush) begin
            model_reset();
            return;
        end
        free = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!mvalid[i]) free = i;
        take = ins_valid && (mcount() < DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (mvalid[i]) begin
                if (wb_hit(ms1[i])) mr1[i] = 1;
                if (wb_hit(ms2[i])) mr2[i] = 1;
            end
        end
        if (disp_valid && mvalid[disp_index]) mvalid[disp_index] = 0;
        if (take) begin
            mvalid[free] = 1;
            ms1[free]    = ins_src1;
            ms2[free]    = ins_src2;
            mid[free]    = ins_al_id;
            mpay[free]   = ins_payload;
            mr1[free]    = ins_src1_rdy || (BYP && wb_hit(ins_src1));
            mr2[free]    = ins_src2_rdy || (BYP && wb_hit(ins_src2));
        end
    endtask

    task automatic check_all();
        logic [DEPTH-1:0] ev, er1, er2;
        ev = '0; er1 = '0; er2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ev[i] = mvalid[i]; er1[i] = mr1[i] && mvalid[i]; er2[i] = mr2[i] && mvalid[i];
        end
        chk("count", count, mcount());
        chk("q_valid", q_valid, ev);
        chk("q_rdy1", q_rdy1 & q_valid, er1);
        chk("q_rdy2", q_rdy2 & q_valid, er2);
        for (int i = 0; i < DEPTH; i++) begin
            if (mvalid[i]) begin
                chk($sformatf("q_src1[%0d]", i), q_src1[i*TAG_W +: TAG_W], ms1[i]);
                chk($sformatf("q_src2[%0d]", i), q_src2[i*TAG_W +: TAG_W], ms2[i]);
                chk($sformatf("q_al_id[%0d]", i), q_al_id[i*ID_W +: ID_W], mid[i]);
                chk($sformatf("q_payload[%0d]", i), q_payload[i*PAYLOAD_W +: PAYLOAD_W], mpay[i]);
            end
        end
    endtask

    task automatic idle();
        ins_valid = 0; ins_src1 = '0; ins_src2 = '0; ins_src1_rdy = 0; ins_src2_rdy = 0;
        ins_al_id = '0; ins_payload = '0; disp_valid = 0; disp_index = '0;
        wb0_valid = 0; wb0_tag = '0; wb1_valid = 0; wb1_tag = '0; flush = 0;
    endtask

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
    task automatic cycle();
        #1;
        chk("ins_ready", ins_ready, (mcount() < DEPTH) && !flush);
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ins(input logic [TAG_W-1:0] s1, input logic [TAG_W-1:0] s2,
                       input bit r1, input bit r2,
                       input logic [ID_W-1:0] id, input logic [PAYLOAD_W-1:0] p);
        ins_valid = 1; ins_src1 = s1; ins_src2 = s2; ins_src1_rdy = r1; ins_src2_rdy = r2;
        ins_al_id = id; ins_payload = p;
        cycle();
        idle();
    endtask

    task automatic do_flush();
        idle(); flush = 1; cycle(); idle();
    endtask

    initial begin
        // reset: outputs quiet even with an offered instruction
        idle();
        model_reset();
        rst_n = 0;
        ins_valid = 1;
        #2;
        chk("rst_q_valid", q_valid, 8'h00);
        chk("rst_count", count, 4'd0);
        chk("rst_ins_ready", ins_ready, 1'b0);
        idle();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        check_all();

        // fill the queue
        for (int k = 0; k < DEPTH; k++)
            ins(TAG_W'(k + 1), TAG_W'(k + 40), 1, 1, ID_W'(k), 40'hA0_0000_0000 + 40'(k));
        #1;
        chk("full_count", count, 4'd8);
        chk("full_ins_ready", ins_ready, 1'b0);
        chk("full_q_valid", q_valid, 8'hFF);

        // dispatch from full with an insert pending: insert must wait
        ins_valid = 1; ins_src1 = 6'd50; ins_src1_rdy = 1; ins_src2_rdy = 1;
        disp_valid = 1; disp_index = 3'd3;
        cycle();
        idle();
        chk("disp3_q_valid", q_valid, 8'hF7);
        chk("disp3_count", count, 4'd7);
        ins(6'd33, 6'd34, 1, 1, 5'd9, 40'h12_3456_789A);
        chk("refill_q_valid", q_valid, 8'hFF);
        chk("refill_slot3", q_src1[3*TAG_W +: TAG_W], 6'd33);

        // wakeup of a waiting source
        do_flush();
        chk("flush_count", count, 4'd0);
        ins(6'd12, 6'd7, 0, 1, 5'd1, 40'h1);
        chk("wait_rdy1", q_rdy1[0], 1'b0);
        wb1_valid = 1; wb1_tag = 6'd13; cycle(); idle();
        chk("wake13_rdy1", q_rdy1[0], 1'b0);
        wb1_valid = 1; wb1_tag = 6'd12; cycle(); idle();
        chk("wake12_rdy1", q_rdy1[0], 1'b1);
        // duplicate tag on both broadcasts
        ins(6'd2, 6'd25, 1, 0, 5'd2, 40'h2);
        wb0_valid = 1; wb0_tag = 6'd25; wb1_valid = 1; wb1_tag = 6'd25; cycle(); idle();
        chk("dup_rdy2", q_rdy2[1], 1'b1);

        // writeback racing an insert
        ins_valid = 1; ins_src1 = 6'd1; ins_src1_rdy = 1; ins_src2 = 6'd20; ins_src2_rdy = 0;
        ins_al_id = 5'd3; ins_payload = 40'h3;
        wb0_valid = 1; wb0_tag = 6'd20;
        cycle();
        idle();
        chk("bypass_rdy2", q_rdy2[2], BYP);

        // flush beats concurrent insert and dispatch
        do_flush();
        for (int k = 0; k < 5; k++) ins(TAG_W'(30 + k), TAG_W'(50 + k), 0, 0, ID_W'(k), 40'(k));
        chk("five_count", count, 4'd5);
        flush = 1; ins_valid = 1; ins_src1 = 6'd9; disp_valid = 1; disp_index = 3'd2;
        cycle();
        idle();
        chk("flush_all_count", count, 4'd0);
        chk("flush_all_q_valid", q_valid, 8'h00);

        // asynchronous reset in the middle of a cycle
        for (int k = 0; k < 4; k++) ins(TAG_W'(k), TAG_W'(k + 8), 1, 0, ID_W'(k), 40'(k + 100));
        chk("four_q_valid", q_valid, 8'h0F);
        #3;
        rst_n = 0;
        #1;
        chk("arst_q_valid", q_valid, 8'h00);
        chk("arst_count", count, 4'd0);
        chk("arst_ins_ready", ins_ready, 1'b0);
        model_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        check_all();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            ins_valid    = ($urandom_range(0, 9) < 6);
            ins_src1     = TAG_W'($urandom_range(0, 15));
            ins_src2     = TAG_W'($urandom_range(0, 15));
            ins_src1_rdy = ($urandom_range(0, 3) == 0);
            ins_src2_rdy = ($urandom_range(0, 3) == 0);
            ins_al_id    = ID_W'($urandom);
            ins_payload  = {8'($urandom), 32'($urandom)};
            disp_valid   = ($urandom_range(0, 1) == 1);
            disp_index   = IDX_W'($urandom);
            wb0_valid    = ($urandom_range(0, 1) == 1);
            wb0_tag      = TAG_W'($urandom_range(0, 15));
            wb1_valid    = ($urandom_range(0, 2) == 0);
            wb1_tag      = TAG_W'($urandom_range(0, 15));
            flush        = ($urandom_range(0, 31) == 0);
            cycle();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
